// File: rtl/alu_mp_add_ctrl_pkg.sv
// Shared definitions for the multi-precision adder sequencer and its word ALU.
package alu_mp_add_ctrl_pkg;

   localparam int ALU_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      INC  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Word i of a packed multi-word vector, with the vector given as a 64-bit window.
   function automatic logic [ALU_W-1:0] word_of(input logic [63:0] vec, input int unsigned i);
      return vec[i*ALU_W +: ALU_W];
   endfunction

endpackage

// File: rtl/alu.sv
// Shared 16-bit combinational adder with carry out and per-word flags.
module alu
   import alu_mp_add_ctrl_pkg::*;
(
   input  logic [ALU_W-1:0] x,
   input  logic [ALU_W-1:0] y,
   output logic [ALU_W-1:0] sum,
   output logic             carry,
   output logic             zero,
   output logic             sign,
   output logic             overflow,
   output logic             parity
);

   assign {carry, sum} = {1'b0, x} + {1'b0, y};
   assign zero         = (sum == '0);
   assign sign         = sum[ALU_W-1];
   assign overflow     = (x[ALU_W-1] == y[ALU_W-1]) && (sum[ALU_W-1] != x[ALU_W-1]);
   assign parity       = ~^sum;

endmodule

// File: rtl/alu_mp_add_ctrl.sv
// Multi-precision add sequencer: one 16-bit word per cycle through the shared ALU, LSW first,
// with carries folded in by a second "+1" pass since the ALU has no carry-in.
//
//   state | meaning
//   IDLE  | waiting for start; result/flags hold last values
//   ADD   | word idx: A[idx] + B[idx]
//   INC   | word idx: res[idx] + 1 to apply the carry from word idx-1
//   DONE  | one-cycle done pulse; result and flags valid
module alu_mp_add_ctrl
   import alu_mp_add_ctrl_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ALU_W*WORDS-1:0] a,
   input  logic [ALU_W*WORDS-1:0] b,
   output logic                   busy,
   output logic                   done,
   output logic [ALU_W*WORDS-1:0] result,
   output logic                   carry_out,
   output logic                   zero,
   output logic                   sign,
   output logic                   overflow,
   output logic                   parity
);

   localparam int RW    = ALU_W * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cin_q, cin_d;
   logic             c1_q, c1_d;
   logic [RW-1:0]    opa_q, opa_d;
   logic [RW-1:0]    opb_q, opb_d;
   logic [RW-1:0]    res_q, res_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             sign_q, sign_d;
   logic             ovf_q, ovf_d;
   logic             par_q, par_d;

   logic [ALU_W-1:0] alu_x, alu_y, alu_sum;
   logic             alu_carry;
   logic [3:0]       alu_flags_unused;

   alu u_alu (
      .x        (alu_x),
      .y        (alu_y),
      .sum      (alu_sum),
      .carry    (alu_carry),
      .zero     (alu_flags_unused[0]),
      .sign     (alu_flags_unused[1]),
      .overflow (alu_flags_unused[2]),
      .parity   (alu_flags_unused[3])
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cin_d   = cin_q;
      c1_d    = c1_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      sign_d  = sign_q;
      ovf_d   = ovf_q;
      par_d   = par_q;
      alu_x   = opa_q[idx_q*ALU_W +: ALU_W];
      alu_y   = opb_q[idx_q*ALU_W +: ALU_W];

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               idx_d   = '0;
               cin_d   = 1'b0;
               state_d = ADD;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         ADD: begin
            res_d[idx_q*ALU_W +: ALU_W] = alu_sum;
            c1_d = alu_carry;
            if (!cin_q) begin
               cin_d = alu_carry;
               if (idx_q == LAST_IDX) state_d = DONE;
               else                   idx_d   = idx_q + IDX_W'(1);
            end else begin
               state_d = INC;
            end
         end
         INC: begin
            alu_x = res_q[idx_q*ALU_W +: ALU_W];
            alu_y = ALU_W'(1);
            res_d[idx_q*ALU_W +: ALU_W] = alu_sum;
            // c1 and the +1 carry are mutually exclusive, so OR is the true carry into idx+1
            cin_d = c1_q | alu_carry;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ADD;
            end
         end
         default: state_d = IDLE;
      endcase

      // Flags are captured from the completed result on the edge that enters DONE.
      if (state_d == DONE && state_q != DONE) begin
         carry_d = cin_d;
         zero_d  = (res_d == '0);
         sign_d  = res_d[RW-1];
         ovf_d   = (opa_q[RW-1] == opb_q[RW-1]) && (res_d[RW-1] != opa_q[RW-1]);
         par_d   = ~^res_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cin_q   <= 1'b0;
         c1_q    <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cin_q   <= cin_d;
         c1_q    <= c1_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
         par_q   <= par_d;
      end
   end

   assign busy      = (state_q == ADD) || (state_q == INC);
   assign done      = (state_q == DONE);
   assign result    = res_q;
   assign carry_out = carry_q;
   assign zero      = zero_q;
   assign sign      = sign_q;
   assign overflow  = ovf_q;
   assign parity    = par_q;

endmodule

// File: tb/tb_alu_mp_add_ctrl.sv
// Directed self-checking bench for the multi-precision adder sequencer (WORDS=4).
module tb_alu_mp_add_ctrl;
   import alu_mp_add_ctrl_pkg::*;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n, start;
   logic [W-1:0] a, b, result;
   logic         busy, done, carry_out, zero, sign, overflow, parity;

   always #5 clk = ~clk;

   alu_mp_add_ctrl #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .sign      (sign),
      .overflow  (overflow),
      .parity    (parity)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] a, b, res;
      logic        c, z, s, v, p;
      int          k;
   } vec_t;

   vec_t vecs[8];

   // Starts an op (caller sits #1 after an edge), returns with done=1 sampled, or on timeout.
   task automatic run_op(input logic [63:0] va, input logic [63:0] vb, input bit inject,
                         output int lat, output int n_inc, output int inc_idx);
      a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~va; b = ~vb;
      check("busy_after_start", busy, 1);
      lat = 0; n_inc = 0; inc_idx = -1;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (dut.state_q == INC) begin
            n_inc++;
            inc_idx = int'(dut.idx_q);
         end
         if (inject && lat == 1) begin
            start = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111;
         end
         if (inject && lat == 2) start = 1'b0;
         if (done) break;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
      end
   endtask

   task automatic check_vec(input vec_t v, input int lat, input int n_inc, input string tag);
      check({tag, "_result"},   result, v.res);
      check({tag, "_carry"},    carry_out, v.c);
      check({tag, "_zero"},     zero, v.z);
      check({tag, "_sign"},     sign, v.s);
      check({tag, "_overflow"}, overflow, v.v);
      check({tag, "_parity"},   parity, v.p);
      check({tag, "_latency"},  64'(lat), 64'(WORDS + v.k));
      check({tag, "_inc_count"}, 64'(n_inc), 64'(v.k));
      check({tag, "_busy_in_done"}, busy, 0);
   endtask

   initial begin
      int lat, n_inc, inc_idx;
      bit saw_done;

      //            a                      b                      result                 c     z     s     v     p     k
      vecs[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3};
      vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
      vecs[5] = '{64'h0001_0000_FFFF_0000, 64'h0001_0000_0001_0000, 64'h0002_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      vecs[7] = '{64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 64'hFFFE_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      check("reset_flags", {carry_out, zero, sign, overflow, parity}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, 1'b0, lat, n_inc, inc_idx);
         check_vec(vecs[i], lat, n_inc, $sformatf("vec%0d", i));
         if (i == 1) check("vec1_inc_idx", 64'(inc_idx), 64'(1));
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_pulse", i), done, 0);
      end

      // start while busy is ignored
      run_op(vecs[1].a, vecs[1].b, 1'b1, lat, n_inc, inc_idx);
      check_vec(vecs[1], lat, n_inc, "busy_start");
      @(posedge clk); #1;
      check("busy_start_idle", busy, 0);

      // back-to-back: second start issued in the DONE cycle
      run_op(vecs[4].a, vecs[4].b, 1'b0, lat, n_inc, inc_idx);
      check_vec(vecs[4], lat, n_inc, "b2b_first");
      run_op(vecs[3].a, vecs[3].b, 1'b0, lat, n_inc, inc_idx);
      check_vec(vecs[3], lat, n_inc, "b2b_second");
      @(posedge clk); #1;

      // async reset mid-operation
      a = vecs[2].a; b = vecs[2].b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midop_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midop_rst_busy", busy, 0);
      check("midop_rst_done", done, 0);
      check("midop_rst_result", result, 0);
      #1;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("midop_no_done_after", saw_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mp_add_ctrl.md
Name: alu_mp_add_ctrl

Overview:
Multi-precision adder sequencer built around the existing 16-bit combinational adder/flag ALU (`alu`: x, y -> sum, carry plus flags).
- Accepts two WORDS×16-bit operands.
- Drives the single ALU one 16-bit word per cycle, LSW first.
- The ALU has no carry-in. A carry into a word is applied by a second ALU pass, sum + 1.
- Produces the wide sum plus whole-result flags. Sits between the register file/operand staging logic and the shared ALU.

Parameters:
WORDS, 4, number of 16-bit words per operand (≥2); the word width is fixed at 16 by the ALU.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
a  in  16*WORDS  operand A, captured when start is accepted
b  in  16*WORDS  operand B, captured when start is accepted
busy  out  1  high in ADD/INC states
done  out  1  one-cycle pulse, result and flags valid
result  out  16*WORDS  registered sum, held until the next accepted start
carry_out  out  1  unsigned carry out of the MSW
zero  out  1  result == 0
sign  out  1  result MSB
overflow  out  1  signed overflow: a_msb==b_msb && result_msb!=a_msb
parity  out  1  ~^result (1 = even number of ones)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry_out=0, zero=0, sign=0, overflow=0, parity=0; idx=0, cin=0. A reset mid-operation aborts; no done is issued.
- FSM states: IDLE, ADD, INC, DONE.
- IDLE/DONE with start=1:
  - Latch a, b into operand registers; idx<=0, cin<=0.
  - Next state ADD. A DONE->ADD back-to-back start is legal.
- ADD:
  - ALU x=A[idx], y=B[idx].
  - res[idx]<=alu_sum; c1<=alu_carry.
  - If cin=0: cin<=alu_carry; if idx==WORDS-1 go DONE, else idx++ and stay in ADD.
  - If cin=1: go INC, keeping idx.
- INC:
  - ALU x=res[idx], y=16'h0001.
  - res[idx]<=alu_sum; cin<=c1|alu_carry. c1 and the INC carry are never both 1.
  - If idx==WORDS-1 go DONE, else idx++ and go to ADD.
- DONE (one cycle):
  - done=1, busy=0.
  - carry_out=final cin.
  - zero, sign, overflow and parity are registered from res and from the latched operand MSBs on entry, so they are valid whenever done=1.
  - No start: go to IDLE.
- Flags come from the full-width result, not from the per-word ALU sign/zero/parity/overflow flags; those ALU outputs are left unused.
- start while busy: ignored. a/b changes while busy: no effect, since operands are latched.
- Latency: start accepted at edge E, done high in the cycle after edge E+WORDS+k.
  - k = number of words i (1..WORDS-1) with a carry into word i.
  - Range: WORDS to 2*WORDS-1 cycles.
- result and flags hold their last values between operations. result is updated word by word while busy; consumers use it only when done=1 or in IDLE.

Decomposition:
- Shared package: ALU_W=16 constant and the state enum {IDLE, ADD, INC, DONE}. Include a word-slice helper if the package style permits.
- Sub-module: the existing `alu` is instantiated once inside. No new sub-module is needed; the FSM, the operand/result word registers and the flag logic stay in this module.

Test Plan:
1. WORDS=4, a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0002 -> result=0x...0003, carry_out=0, zero=0, overflow=0, parity=1 (0x3 has two ones, so even); done exactly 4 cycles after start (k=0).
2. a=0x0000_0000_0000_FFFF, b=0x...0001 -> result=0x0000_0000_0001_0000, carry_out=0, k=1, done at 5 cycles; exactly one INC state observed, at idx=1.
3. a=0xFFFF_FFFF_FFFF_FFFF, b=0x...0001 -> result=0, carry_out=1, zero=1, parity=1, overflow=0, sign=0; k=3, done at 7 cycles.
4. a=0x7FFF_FFFF_FFFF_FFFF, b=0x...0001 -> result=0x8000_0000_0000_0000, sign=1, overflow=1, carry_out=0, k=3.
5. a=b=0x8000_0000_0000_0000 -> result=0, carry_out=1, overflow=1, zero=1, k=0, done at 4 cycles.
6. Control cases:
   - start pulsed while busy -> ignored, original result unchanged.
   - rst_n pulled low mid-op -> busy=0, done=0, result=0 immediately (async); no done after release.
   - Back-to-back start in the DONE cycle -> second op begins with no IDLE gap.
